// File: rtl/mem_bus_arbiter.sv
// Data-over-fetch memory bus arbiter: grant 1 cycle after request, ack combinational with bus_ready.
// Requesters stall (hold req) until ack; optional ARB_TIMEOUT_EN aborts a stuck slave with bus_err.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_d_q;
   logic   grant_d, grant_if;
   logic   busy, done, abort;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
   end

   assign busy = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // bus_ready on the terminal-count cycle is a normal completion, not an abort
   assign abort = busy && !bus_ready && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!busy) begin
         cnt_q <= '0;
      end else if (!bus_ready) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   assign done    = busy && (bus_ready || abort);
   assign bus_err = abort;
   assign bus_req = busy;

   always_comb begin
      state_d  = state_q;
      grant_d  = 1'b0;
      grant_if = 1'b0;
      case (state_q)
         IDLE: begin
            // data wins unless the previous grant was data and fetch is also waiting
            if (d_req && (!if_req || !last_d_q)) begin
               state_d = D_BUSY;
               grant_d = 1'b1;
            end else if (if_req) begin
               state_d  = IF_BUSY;
               grant_if = 1'b1;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (done) last_d_q <= (state_q == D_BUSY);
      end
   end

   // Transaction fields are captured only at grant so requester changes mid-flight never reach the bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
      end else if (grant_d) begin
         bus_we    <= d_we;
         bus_addr  <= d_addr;
         bus_wdata <= d_wdata;
         bus_wstrb <= d_wstrb;
      end else if (grant_if) begin
         bus_we    <= 1'b0;
         bus_addr  <= if_addr;
         bus_wdata <= '0;
         bus_wstrb <= '0;
      end
   end

   assign if_ack    = (state_q == IF_BUSY) && done;
   assign d_ack     = (state_q == D_BUSY) && done;
   assign if_rdata  = abort ? 32'd0 : bus_rdata;
   assign d_rdata   = abort ? 32'd0 : bus_rdata;
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES=4; abort case only with ARB_TIMEOUT_EN).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, bus_ready;
   logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
   logic [3:0]  d_wstrb;
   logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
   logic        if_ack, d_ack, bus_req, bus_we, stall_if, stall_mem, bus_err;
   logic [3:0]  bus_wstrb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; bus_ready = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; bus_rdata = 0;

      // reset state
      next_cycle(); next_cycle(); mid();
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_bus_wstrb", bus_wstrb, 4'h0);
      chk("rst_if_ack", if_ack, 1'b0);
      chk("rst_d_ack", d_ack, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      next_cycle(); rst_n = 1'b1;

      // bus_ready in IDLE is ignored
      bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
      mid();
      chk("idle_ready_if_ack", if_ack, 1'b0);
      chk("idle_ready_d_ack", d_ack, 1'b0);
      chk("idle_ready_bus_req", bus_req, 1'b0);

      // single fetch, zero-wait slave
      next_cycle(); bus_ready = 1'b0; if_req = 1'b1; if_addr = 32'h100;
      mid();
      chk("f_stall_before", stall_if, 1'b1);
      chk("f_bus_req_idle", bus_req, 1'b0);
      next_cycle(); bus_ready = 1'b1; bus_rdata = 32'h0050_0093;
      mid();
      chk("f_bus_req", bus_req, 1'b1);
      chk("f_bus_addr", bus_addr, 32'h100);
      chk("f_bus_we", bus_we, 1'b0);
      chk("f_bus_wstrb", bus_wstrb, 4'h0);
      chk("f_if_ack", if_ack, 1'b1);
      chk("f_if_rdata", if_rdata, 32'h0050_0093);
      chk("f_d_ack", d_ack, 1'b0);
      chk("f_stall_ack", stall_if, 1'b0);
      chk("f_bus_err", bus_err, 1'b0);
      next_cycle(); bus_ready = 1'b0; if_req = 1'b0;
      mid();
      chk("f_after_bus_req", bus_req, 1'b0);
      chk("f_after_if_ack", if_ack, 1'b0);
      chk("f_after_stall", stall_if, 1'b0);

      // store with a 3-cycle slave wait
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      mid();
      chk("s_stall_idle", stall_mem, 1'b1);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); mid();
         chk("s_wait_bus_req", bus_req, 1'b1);
         chk("s_wait_addr", bus_addr, 32'h2000);
         chk("s_wait_wdata", bus_wdata, 32'hDEAD_BEEF);
         chk("s_wait_d_ack", d_ack, 1'b0);
         chk("s_wait_stall", stall_mem, 1'b1);
      end
      next_cycle(); bus_ready = 1'b1; bus_rdata = 32'hCAFE_0000;
      mid();
      chk("s_d_ack", d_ack, 1'b1);
      chk("s_bus_we", bus_we, 1'b1);
      chk("s_bus_wstrb", bus_wstrb, 4'hF);
      chk("s_stall_ack", stall_mem, 1'b0);
      chk("s_if_ack", if_ack, 1'b0);
      next_cycle(); bus_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;

      // fresh reset so last_d=0, then both held: D, IF, D, IF
      rst_n = 1'b0; next_cycle(); rst_n = 1'b1;
      d_req = 1'b1; if_req = 1'b1; d_addr = 32'h3000; if_addr = 32'h400;
      for (int g = 0; g < 4; g++) begin
         mid();
         chk("alt_idle_bus_req", bus_req, 1'b0);
         chk("alt_idle_ack", {30'd0, if_ack, d_ack}, 32'd0);
         next_cycle(); bus_ready = 1'b1; bus_rdata = 32'hA0 + g;
         mid();
         chk("alt_bus_req", bus_req, 1'b1);
         chk("alt_bus_addr", bus_addr, (g % 2 == 0) ? 32'h3000 : 32'h400);
         chk("alt_d_ack", d_ack, (g % 2 == 0) ? 1'b1 : 1'b0);
         chk("alt_if_ack", if_ack, (g % 2 == 0) ? 1'b0 : 1'b1);
         chk("alt_rdata", (g % 2 == 0) ? d_rdata : if_rdata, 32'hA0 + g);
         next_cycle(); bus_ready = 1'b0;
      end
      d_req = 1'b0; if_req = 1'b0;

      // address change mid-transaction does not reach the bus
      next_cycle(); if_req = 1'b1; if_addr = 32'h100;
      next_cycle(); if_addr = 32'h200;
      mid();
      chk("mc_addr1", bus_addr, 32'h100);
      next_cycle(); mid();
      chk("mc_addr2", bus_addr, 32'h100);
      next_cycle(); bus_ready = 1'b1; bus_rdata = 32'h77;
      mid();
      chk("mc_addr_ack", bus_addr, 32'h100);
      chk("mc_if_ack", if_ack, 1'b1);
      next_cycle(); bus_ready = 1'b0; if_req = 1'b0;

      // reset during D_BUSY
      next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
      next_cycle(); mid();
      chk("rm_busy", bus_req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_bus_req_async", bus_req, 1'b0);
      chk("rm_no_d_ack", d_ack, 1'b0);
      chk("rm_bus_addr_clr", bus_addr, 32'h0);
      next_cycle(); rst_n = 1'b1;
      mid();
      chk("rm_idle_after", bus_req, 1'b0);
      next_cycle(); bus_ready = 1'b1; bus_rdata = 32'h55;
      mid();
      chk("rm_regrant_addr", bus_addr, 32'h5000);
      chk("rm_regrant_ack", d_ack, 1'b1);
      chk("rm_regrant_rdata", d_rdata, 32'h55);
      next_cycle(); bus_ready = 1'b0; d_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
      // no bus_ready: abort on the 4th busy cycle
      next_cycle(); d_req = 1'b1; d_addr = 32'h6000; bus_rdata = 32'hAAAA_AAAA;
      for (int i = 0; i < 3; i++) begin
         next_cycle(); mid();
         chk("to_wait_ack", d_ack, 1'b0);
         chk("to_wait_err", bus_err, 1'b0);
      end
      next_cycle(); mid();
      chk("to_d_ack", d_ack, 1'b1);
      chk("to_bus_err", bus_err, 1'b1);
      chk("to_d_rdata", d_rdata, 32'h0);
      next_cycle(); d_req = 1'b0;
      mid();
      chk("to_idle", bus_req, 1'b0);
      chk("to_err_clear", bus_err, 1'b0);
`endif

      next_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the CPU's single external memory bus between the instruction-fetch stage and the data-memory stage of the pipelined core. Each transaction is latched at grant, the bus is held stable until the slave responds, the response is routed back to the owning requester, and stall signals are produced for the hazard logic. Data requests beat fetch requests, with an alternation rule that keeps fetch from starving.

## Interface
- `TIMEOUT_CYCLES`, 256: busy cycles without `bus_ready` before abort. Used only with `ARB_TIMEOUT_EN`. Must be ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  32  fetch word address.
- `if_rdata`  out  32  fetched instruction; valid only when `if_ack`=1.
- `if_ack`  out  1  fetch complete.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1=store, 0=load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_wstrb`  in  4  store byte enables.
- `d_rdata`  out  32  load data; valid only when `d_ack`=1.
- `d_ack`  out  1  data transaction complete.
- `bus_req`  out  1  bus transaction active.
- `bus_we`, `bus_addr[31:0]`, `bus_wdata[31:0]`, `bus_wstrb[3:0]`  out  latched transaction fields.
- `bus_ready`  in  1  slave completion; one-cycle pulse.
- `bus_rdata`  in  32  slave read data; valid with `bus_ready`.
- `stall_if`  out  1  `if_req & ~if_ack`.
- `stall_mem`  out  1  `d_req & ~d_ack`.
- `bus_err`  out  1  one-cycle pulse with an ack when the transaction was aborted.

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY. Flag `last_d` records that the last completed grant was a data grant.
- IDLE grant decision:
  - Only `d_req` → D_BUSY.
  - Only `if_req` → IF_BUSY.
  - Both asserted and `last_d`=1 → IF_BUSY.
  - Both asserted and `last_d`=0 → D_BUSY.
  - Neither → stay in IDLE.
- On grant, latch the winner's fields into the `bus_*` registers. For a fetch grant, `bus_we`=0 and `bus_wstrb`=0.
- Busy state, `bus_ready`=1:
  - Ack the owner combinationally in the same cycle: `x_ack`=1, `x_rdata`=`bus_rdata`.
  - Return to IDLE on that edge and clear `bus_req`.
  - Set `last_d` to (state==D_BUSY).
- `bus_ready` in IDLE is ignored; no ack is produced.
- The non-owner's ack stays 0. `d_rdata` on a store ack carries `bus_rdata` and has no meaning.
- Requester inputs are not re-sampled while busy. If a requester changes address mid-transaction, the bus is unaffected.
- Reset: FSM goes to IDLE and `last_d` to 0. `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb` and `bus_err` go to 0. Both acks are 0.

## Timing
- Grant latency: request seen in IDLE at edge N → `bus_req`=1 in cycle N+1.
- Earliest completion: `bus_ready` in cycle N+1 gives ack in cycle N+1. The minimum transaction is 2 cycles from request to ack.
- Back-to-back: the cycle after an ack is IDLE. A request held or newly raised in that cycle is granted at its end. Sustained throughput is 1 transaction per 2 cycles with a zero-wait slave.
- `stall_*` and the acks are combinational from registered state plus `bus_ready`. There is no combinational path from `*_req` to any `bus_*` output.
- Reset asserted mid-transaction: `bus_req` drops asynchronously, no ack is issued, and the requester must re-issue.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A busy counter clears on grant and increments each busy cycle without `bus_ready`.
  - When the count reaches `TIMEOUT_CYCLES-1` with no `bus_ready`, the block aborts: the owner's ack = 1, its rdata = 0, `bus_err`=1 for that cycle, and the FSM returns to IDLE.
  - `bus_ready` arriving on the abort cycle wins: normal completion, `bus_err`=0.
- `ARB_TIMEOUT_EN` undefined: no counter. Busy states wait indefinitely and `bus_err` is tied to 0.

## Test plan
- Single fetch, `if_addr`=0x100, `bus_ready` 1 cycle after `bus_req` with `bus_rdata`=0x00500093 → `bus_addr`=0x100, `bus_we`=0, `if_ack`=1 with `if_rdata`=0x00500093 in cycle 2, `stall_if` low thereafter.
- Store, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF, slave waits 3 cycles → `bus_*` stable for 3 cycles, `d_ack` in the `bus_ready` cycle, `stall_mem`=1 until then.
- Simultaneous `if_req`+`d_req` held continuously after reset → grant order D, IF, D, IF; ack every 2nd cycle with a zero-wait slave.
- Change `if_addr` from 0x100 to 0x200 mid-transaction → `bus_addr` stays 0x100 until ack.
- `rst_n` pulsed low during D_BUSY → `bus_req`=0 immediately, no `d_ack`, and the next grant after release starts cleanly.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no `bus_ready` → `d_ack`=1, `bus_err`=1, `d_rdata`=0 on the 4th busy cycle, then IDLE.
